// File: rtl/muldiv_alu.sv
// Multicycle ALU: registered one-cycle base integer ops plus iterative RV M-extension mul/div.
// Optional MULDIV_FASTPATH_EN: M ops with a zero divisor or multiplicand complete like base ops.
module muldiv_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            mext,
  input  logic [2:0]      funct3,
  input  logic            alt,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] res
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [SHW-1:0]    count_q, count_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [2:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic              divz_q, divz_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic              done_q, done_d;

  logic              accept, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag, base_res;
  logic [SHW-1:0]    shamt;
  logic [XLEN:0]     add_sum, shifted, diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign done   = done_q;
  assign res    = res_q;
  assign accept = start && !busy;

  // Signedness per funct3: MULHU/DIVU/REMU unsigned, MULHSU signed a with unsigned b.
  assign a_sgn = !(funct3[0] && (funct3[1] || funct3[2]));
  assign b_sgn = a_sgn && (funct3 != 3'b010);
  assign a_neg = a_sgn && srca[XLEN-1];
  assign b_neg = b_sgn && srcb[XLEN-1];
  assign a_mag = a_neg ? -srca : srca;
  assign b_mag = b_neg ? -srcb : srcb;

  always_comb begin
    shamt = srcb[SHW-1:0];
    unique case (funct3)
      3'b000:  base_res = alt ? srca - srcb : srca + srcb;
      3'b001:  base_res = srca << shamt;
      3'b010:  base_res = {{(XLEN-1){1'b0}}, $signed(srca) < $signed(srcb)};
      3'b011:  base_res = {{(XLEN-1){1'b0}}, srca < srcb};
      3'b100:  base_res = srca ^ srcb;
      3'b101:  base_res = alt ? $unsigned($signed(srca) >>> shamt) : srca >> shamt;
      3'b110:  base_res = srca | srcb;
      default: base_res = srca & srcb;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_d      = a_q;
    op_d     = op_q;
    neg_d    = neg_q;
    divz_d   = divz_q;
    res_d    = res_q;
    done_d   = 1'b0;
    add_sum  = '0;
    shifted  = '0;
    diff     = '0;
    prod_fix = '0;
    quo_fix  = '0;
    rem_fix  = '0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          if (!mext) begin
            res_d  = base_res;
            done_d = 1'b1;
          end
`ifdef MULDIV_FASTPATH_EN
          else if (srcb == '0 || (!funct3[2] && srca == '0)) begin
            res_d  = !funct3[2] ? '0 : (funct3[1] ? srca : '1);
            done_d = 1'b1;
          end
`endif
          else begin
            state_d = S_CALC;
            count_d = '0;
            op_d    = funct3;
            a_d     = srca;
            divz_d  = funct3[2] && (srcb == '0);
            // acc holds {hi, multiplier} for mul and {remainder, dividend/quotient} for div.
            if (!funct3[2]) begin
              acc_d  = {{XLEN{1'b0}}, b_mag};
              opnd_d = a_mag;
              neg_d  = a_neg ^ b_neg;
            end else begin
              acc_d  = {{XLEN{1'b0}}, a_mag};
              opnd_d = b_mag;
              neg_d  = funct3[1] ? a_neg : (a_neg ^ b_neg);
            end
          end
        end
      end
      S_CALC: begin
        if (!op_q[2]) begin
          add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
          acc_d   = {add_sum, acc_q[XLEN-1:1]};
        end else begin
          shifted = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
          diff    = shifted - {1'b0, opnd_q};
          if (!diff[XLEN]) acc_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          else             acc_d = {shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        end
        count_d = count_q + 1'b1;
        if (count_q == SHW'(XLEN-1)) begin
          state_d = S_FIX;
          count_d = '0;
        end
      end
      S_FIX: begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fix  = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (!op_q[2])     res_d = (op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        else if (!op_q[1]) res_d = divz_q ? '1 : quo_fix;
        else               res_d = divz_q ? a_q : rem_fix;
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      a_q     <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      divz_q  <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      a_q     <= a_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      divz_q  <= divz_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end
endmodule
